spi_cmd: RTL and testbench

Command decoder directly downstream of `spi_byte`. It consumes the received SPI byte stream, assembles read/write commands targeting the 17-bit system bus address space, and issues one bus transaction per command to the bus sequencer. It returns read data as the next SPI transmit byte and raises `spi_ready_o` to tell the host (RP2040) that the transaction has completed.

---
 rtl/spi_cmd_pkg.sv | 29 ++
 rtl/spi_cmd.sv | 120 ++++++++++++
 tb/tb_spi_cmd.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_cmd_pkg.sv
// Shared types and constants for the SPI command decoder.
package spi_cmd_pkg;

   localparam int BUS_ADDR_WIDTH = 17;

   typedef enum logic [2:0] {
      OP_WRITE_AT   = 3'b000,
      OP_READ_AT    = 3'b001,
      OP_WRITE_NEXT = 3'b010,
      OP_READ_NEXT  = 3'b011
   } spi_cmd_op_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARGS  = 2'd1,
      ISSUE = 2'd2,
      DONE  = 2'd3
   } spi_cmd_state_t;

   // Argument byte count indexed by opcode; reserved opcodes read as 0.
   localparam logic [7:0][1:0] SPI_CMD_ARGS = '{
      2'd0, 2'd0, 2'd0, 2'd0,   // 7..4 reserved
      2'd0,                     // READ_NEXT
      2'd1,                     // WRITE_NEXT
      2'd2,                     // READ_AT
      2'd3                      // WRITE_AT
   };

endpackage

// File: rtl/spi_cmd.sv
// SPI byte-stream command decoder: assembles read/write commands and issues
// one bus request per command, returning read data as the next tx byte.
module spi_cmd
   import spi_cmd_pkg::*;
(
   input  logic                      clk_sys_i,
   input  logic                      reset_ni,
   input  logic                      spi_reset_i,
   input  logic                      rx_valid_i,
   input  logic [7:0]                rx_byte_i,
   output logic [7:0]                tx_byte_o,
   output logic                      spi_ready_o,
   output logic                      cmd_valid_o,
   input  logic                      cmd_done_i,
   output logic [BUS_ADDR_WIDTH-1:0] cmd_addr_o,
   output logic [7:0]                cmd_data_o,
   output logic                      cmd_rw_no,
   input  logic [7:0]                cmd_rd_data_i
);

   spi_cmd_state_t r_state;
   spi_cmd_op_t    r_op;
   logic           r_a16;
   logic [1:0]     r_cnt;
   logic [7:0]     r_addr_hi;
   logic           r_abort;

   logic [BUS_ADDR_WIDTH-1:0] w_addr_next;
   logic                      w_rx_op_ok;
   logic [1:0]                w_rx_args;
   logic                      w_op_rd;
   logic                      w_op_wr;
   logic                      w_op_next;

   assign w_addr_next = cmd_addr_o + 17'd1;
   assign w_rx_op_ok  = (rx_byte_i[7:5] == OP_WRITE_AT)   || (rx_byte_i[7:5] == OP_READ_AT) ||
                        (rx_byte_i[7:5] == OP_WRITE_NEXT) || (rx_byte_i[7:5] == OP_READ_NEXT);
   assign w_rx_args   = SPI_CMD_ARGS[rx_byte_i[7:5]];
   assign w_op_rd     = (r_op == OP_READ_AT)    || (r_op == OP_READ_NEXT);
   assign w_op_wr     = (r_op == OP_WRITE_AT)   || (r_op == OP_WRITE_NEXT);
   assign w_op_next   = (r_op == OP_WRITE_NEXT) || (r_op == OP_READ_NEXT);

   always_ff @(posedge clk_sys_i) begin
      if (!reset_ni) begin
         r_state     <= IDLE;
         r_op        <= OP_WRITE_AT;
         r_a16       <= 1'b0;
         r_cnt       <= 2'd0;
         r_addr_hi   <= 8'h00;
         r_abort     <= 1'b0;
         tx_byte_o   <= 8'h00;
         spi_ready_o <= 1'b0;
         cmd_valid_o <= 1'b0;
         cmd_addr_o  <= '0;
         cmd_data_o  <= 8'h00;
         cmd_rw_no   <= 1'b1;
      end else begin
         case (r_state)
            IDLE: begin
               if (!spi_reset_i && rx_valid_i && w_rx_op_ok) begin
                  r_op  <= spi_cmd_op_t'(rx_byte_i[7:5]);
                  r_a16 <= rx_byte_i[0];
                  r_cnt <= w_rx_args;
                  if (w_rx_args == 2'd0) begin
                     // Only READ_NEXT has no arguments, so it always increments.
                     cmd_valid_o <= 1'b1;
                     cmd_rw_no   <= rx_byte_i[5];
                     cmd_addr_o  <= w_addr_next;
                     r_state     <= ISSUE;
                  end else begin
                     r_state <= ARGS;
                  end
               end
            end
            ARGS: begin
               if (spi_reset_i) begin
                  r_state <= IDLE;
               end else if (rx_valid_i) begin
                  // Data is always the first argument of a write.
                  if (w_op_wr && r_cnt == SPI_CMD_ARGS[r_op])
                     cmd_data_o <= rx_byte_i;
                  else if (r_cnt == 2'd2)
                     r_addr_hi <= rx_byte_i;
                  r_cnt <= r_cnt - 2'd1;
                  if (r_cnt == 2'd1) begin
                     cmd_valid_o <= 1'b1;
                     cmd_rw_no   <= w_op_rd;
                     cmd_addr_o  <= w_op_next ? w_addr_next : {r_a16, r_addr_hi, rx_byte_i};
                     r_state     <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               if (spi_reset_i)
                  r_abort <= 1'b1;
               if (cmd_done_i) begin
                  cmd_valid_o <= 1'b0;
                  if (r_abort || spi_reset_i) begin
                     r_abort <= 1'b0;
                     r_state <= IDLE;
                  end else begin
                     if (w_op_rd)
                        tx_byte_o <= cmd_rd_data_i;
                     spi_ready_o <= 1'b1;
                     r_state     <= DONE;
                  end
               end
            end
            DONE: begin
               if (spi_reset_i) begin
                  spi_ready_o <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_cmd.sv
// Directed self-checking bench for spi_cmd.
module tb_spi_cmd;

   logic        clk_sys_i = 1'b0;
   logic        reset_ni = 1'b0;
   logic        spi_reset_i = 1'b0;
   logic        rx_valid_i = 1'b0;
   logic [7:0]  rx_byte_i = 8'h00;
   logic [7:0]  tx_byte_o;
   logic        spi_ready_o;
   logic        cmd_valid_o;
   logic        cmd_done_i = 1'b0;
   logic [16:0] cmd_addr_o;
   logic [7:0]  cmd_data_o;
   logic        cmd_rw_no;
   logic [7:0]  cmd_rd_data_i = 8'h00;

   int n_checks = 0;
   int n_errors = 0;

   spi_cmd dut (
      .clk_sys_i     (clk_sys_i),
      .reset_ni      (reset_ni),
      .spi_reset_i   (spi_reset_i),
      .rx_valid_i    (rx_valid_i),
      .rx_byte_i     (rx_byte_i),
      .tx_byte_o     (tx_byte_o),
      .spi_ready_o   (spi_ready_o),
      .cmd_valid_o   (cmd_valid_o),
      .cmd_done_i    (cmd_done_i),
      .cmd_addr_o    (cmd_addr_o),
      .cmd_data_o    (cmd_data_o),
      .cmd_rw_no     (cmd_rw_no),
      .cmd_rd_data_i (cmd_rd_data_i)
   );

   always #5 clk_sys_i = ~clk_sys_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Inputs change on the falling edge; outputs are sampled there too.
   task automatic send(input logic [7:0] b);
      rx_byte_i  = b;
      rx_valid_i = 1'b1;
      @(negedge clk_sys_i);
      rx_valid_i = 1'b0;
   endtask

   task automatic frame_abort();
      spi_reset_i = 1'b1;
      @(negedge clk_sys_i);
      spi_reset_i = 1'b0;
   endtask

   task automatic bus_done(input logic [7:0] rd);
      cmd_rd_data_i = rd;
      cmd_done_i    = 1'b1;
      @(negedge clk_sys_i);
      cmd_done_i    = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk_sys_i);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, ".valid"}, 32'(cmd_valid_o), 32'd0);
      chk({tag, ".addr"},  32'(cmd_addr_o),  32'h0);
      chk({tag, ".data"},  32'(cmd_data_o),  32'h0);
      chk({tag, ".rw"},    32'(cmd_rw_no),   32'd1);
      chk({tag, ".tx"},    32'(tx_byte_o),   32'h0);
      chk({tag, ".ready"}, 32'(spi_ready_o), 32'd0);
   endtask

   initial begin
      idle(3);
      chk_reset_vals("por");
      reset_ni = 1'b1;
      idle(1);

      // READ_AT 0x18000
      send(8'h21); send(8'h80); send(8'h00);
      chk("rd_at.valid", 32'(cmd_valid_o), 32'd1);
      chk("rd_at.addr",  32'(cmd_addr_o),  32'h18000);
      chk("rd_at.rw",    32'(cmd_rw_no),   32'd1);
      idle(2);
      chk("rd_at.hold",  32'(cmd_valid_o), 32'd1);
      bus_done(8'h5A);
      chk("rd_at.vfall", 32'(cmd_valid_o), 32'd0);
      chk("rd_at.tx",    32'(tx_byte_o),   32'h5A);
      chk("rd_at.ready", 32'(spi_ready_o), 32'd1);
      send(8'h60);
      chk("done.rx_ign", 32'(cmd_valid_o), 32'd0);
      chk("done.ready",  32'(spi_ready_o), 32'd1);
      frame_abort();
      chk("rd_at.rdy0",  32'(spi_ready_o), 32'd0);

      // WRITE_AT 0x08000 <- A5
      send(8'h00); send(8'hA5); send(8'h80); send(8'h00);
      chk("wr_at.valid", 32'(cmd_valid_o), 32'd1);
      chk("wr_at.addr",  32'(cmd_addr_o),  32'h08000);
      chk("wr_at.data",  32'(cmd_data_o),  32'hA5);
      chk("wr_at.rw",    32'(cmd_rw_no),   32'd0);
      bus_done(8'h33);
      chk("wr_at.tx",    32'(tx_byte_o),   32'h5A);
      chk("wr_at.ready", 32'(spi_ready_o), 32'd1);
      frame_abort();

      // READ_AT 0x1FFFF then READ_NEXT wraps to 0
      send(8'h21); send(8'hFF); send(8'hFF);
      chk("rd_top.addr", 32'(cmd_addr_o),  32'h1FFFF);
      bus_done(8'h77);
      chk("rd_top.tx",   32'(tx_byte_o),   32'h77);
      frame_abort();
      send(8'h60);
      chk("wrap.valid",  32'(cmd_valid_o), 32'd1);
      chk("wrap.addr",   32'(cmd_addr_o),  32'h00000);
      chk("wrap.rw",     32'(cmd_rw_no),   32'd1);
      bus_done(8'h12);
      chk("wrap.tx",     32'(tx_byte_o),   32'h12);
      frame_abort();

      // Partial WRITE_AT aborted by frame reset
      send(8'h00); send(8'h11);
      frame_abort();
      idle(1);
      chk("part.valid",  32'(cmd_valid_o), 32'd0);
      send(8'h60);
      chk("part.nxt_v",  32'(cmd_valid_o), 32'd1);
      chk("part.nxt_a",  32'(cmd_addr_o),  32'h00001);
      bus_done(8'h44);
      chk("part.tx",     32'(tx_byte_o),   32'h44);
      frame_abort();

      // Frame reset during ISSUE: bus cycle completes, result discarded
      send(8'h60);
      chk("abrt.addr",   32'(cmd_addr_o),  32'h00002);
      frame_abort();
      idle(4);
      chk("abrt.hold",   32'(cmd_valid_o), 32'd1);
      bus_done(8'h99);
      chk("abrt.vfall",  32'(cmd_valid_o), 32'd0);
      chk("abrt.ready",  32'(spi_ready_o), 32'd0);
      chk("abrt.tx",     32'(tx_byte_o),   32'h44);
      bus_done(8'hEE);
      chk("stray.ready", 32'(spi_ready_o), 32'd0);
      chk("stray.tx",    32'(tx_byte_o),   32'h44);

      // Byte and frame reset together: reset wins
      spi_reset_i = 1'b1;
      send(8'h60);
      spi_reset_i = 1'b0;
      chk("race.valid",  32'(cmd_valid_o), 32'd0);

      // Reserved opcode ignored, then READ_NEXT continues from 0x00002
      send(8'hE0);
      chk("resv.valid",  32'(cmd_valid_o), 32'd0);
      send(8'h60);
      chk("resv.nxt_v",  32'(cmd_valid_o), 32'd1);
      chk("resv.nxt_a",  32'(cmd_addr_o),  32'h00003);
      bus_done(8'h10);
      chk("resv.tx",     32'(tx_byte_o),   32'h10);
      frame_abort();

      // WRITE_NEXT uses incremented address
      send(8'h40); send(8'h5C);
      chk("wrn.addr",    32'(cmd_addr_o),  32'h00004);
      chk("wrn.data",    32'(cmd_data_o),  32'h5C);
      chk("wrn.rw",      32'(cmd_rw_no),   32'd0);
      bus_done(8'h00);
      frame_abort();

      // System reset mid-ARGS
      send(8'h00); send(8'hAA);
      reset_ni = 1'b0;
      idle(1);
      chk_reset_vals("rst_args");
      reset_ni = 1'b1;

      // System reset mid-ISSUE drops valid immediately
      send(8'h60);
      chk("rst_iss.pre", 32'(cmd_valid_o), 32'd1);
      chk("rst_iss.adr", 32'(cmd_addr_o),  32'h00001);
      reset_ni = 1'b0;
      idle(1);
      chk("rst_iss.v",   32'(cmd_valid_o), 32'd0);
      reset_ni = 1'b1;
      idle(1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
